// File: rtl/gyro_spi_reader.sv
// SPI mode-3 controller for an MPU-style IMU: one power-management write after reset,
// then a 6-byte gyro burst read on every sample tick, published as signed gx/gy/gz.
module gyro_spi_reader #(
    parameter int         CLK_DIV       = 50,
    parameter int         SAMPLE_PERIOD = 100000,
    parameter logic [7:0] INIT_ADDR     = 8'h6B,
    parameter logic [7:0] INIT_DATA     = 8'h00,
    parameter logic [7:0] GYRO_ADDR     = 8'h43
) (
    input  logic               clk_100mhz,
    input  logic               rst_in,
    input  logic               enable,
    input  logic               cipo,
    output logic               copi,
    output logic               sclk,
    output logic               cs_n,
    output logic signed [15:0] gx,
    output logic signed [15:0] gy,
    output logic signed [15:0] gz,
    output logic               valid,
    output logic               init_done,
    output logic               overrun
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(SAMPLE_PERIOD);

    localparam logic [2:0] S_INIT_START = 3'd0;
    localparam logic [2:0] S_XFER       = 3'd1;
    localparam logic [2:0] S_GAP        = 3'd2;
    localparam logic [2:0] S_WAIT_TICK  = 3'd3;
    localparam logic [2:0] S_PUBLISH    = 3'd4;

    localparam logic [7:0] INIT_CMD = INIT_ADDR & 8'h7F;
    localparam logic [7:0] READ_CMD = 8'h80 | GYRO_ADDR;

    // Half-period index: 0 = lead-in, 1..16*nbytes = sclk low/high halves, last = tail.
    localparam logic [6:0] INIT_LAST_HALF = 7'd33;
    localparam logic [6:0] READ_LAST_HALF = 7'd113;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

    logic [2:0]        state_reg;
    logic [DIV_W-1:0]  div_reg;
    logic [6:0]        half_reg;
    logic              is_read_reg;
    logic [54:0]       tx_reg;
    logic [47:0]       rx_reg;
    logic              cs_n_reg;
    logic              sclk_reg;
    logic              copi_reg;
    logic signed [15:0] gx_reg;
    logic signed [15:0] gy_reg;
    logic signed [15:0] gz_reg;
    logic              valid_reg;
    logic              init_done_reg;
    logic              overrun_reg;
    logic [CNT_W-1:0]  sample_cnt_reg;

    logic [6:0] half_next;
    logic [6:0] last_half;
    logic       tick;

    assign half_next = half_reg + 7'd1;
    assign last_half = is_read_reg ? READ_LAST_HALF : INIT_LAST_HALF;
    assign tick      = init_done_reg && (sample_cnt_reg == CNT_LAST);

    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) begin
            state_reg      <= S_INIT_START;
            div_reg        <= '0;
            half_reg       <= '0;
            is_read_reg    <= 1'b0;
            tx_reg         <= '0;
            rx_reg         <= '0;
            cs_n_reg       <= 1'b1;
            sclk_reg       <= 1'b1;
            copi_reg       <= 1'b0;
            gx_reg         <= '0;
            gy_reg         <= '0;
            gz_reg         <= '0;
            valid_reg      <= 1'b0;
            init_done_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
            sample_cnt_reg <= '0;
        end else begin
            valid_reg <= 1'b0;
            if (init_done_reg)
                sample_cnt_reg <= tick ? '0 : sample_cnt_reg + CNT_W'(1);
            if (tick && state_reg != S_WAIT_TICK)
                overrun_reg <= 1'b1;

            case (state_reg)
                S_INIT_START: begin
                    tx_reg      <= {INIT_CMD[6:0], INIT_DATA, 40'd0};
                    copi_reg    <= INIT_CMD[7];
                    is_read_reg <= 1'b0;
                    cs_n_reg    <= 1'b0;
                    div_reg     <= '0;
                    half_reg    <= '0;
                    state_reg   <= S_XFER;
                end
                S_WAIT_TICK: begin
                    if (tick && enable) begin
                        tx_reg      <= {READ_CMD[6:0], 48'd0};
                        copi_reg    <= READ_CMD[7];
                        is_read_reg <= 1'b1;
                        cs_n_reg    <= 1'b0;
                        div_reg     <= '0;
                        half_reg    <= '0;
                        state_reg   <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (div_reg == DIV_LAST) begin
                        div_reg  <= '0;
                        half_reg <= half_next;
                        if (half_reg == last_half) begin
                            cs_n_reg  <= 1'b1;
                            copi_reg  <= 1'b0;
                            state_reg <= is_read_reg ? S_PUBLISH : S_GAP;
                        end else if (half_next == last_half) begin
                            sclk_reg <= 1'b1;
                        end else if (half_next[0]) begin
                            // Bit 7 of byte 0 is already on copi from cs_n fall; later bits shift on each fall.
                            sclk_reg <= 1'b0;
                            if (half_reg != 7'd0) begin
                                copi_reg <= tx_reg[54];
                                tx_reg   <= {tx_reg[53:0], 1'b0};
                            end
                        end else begin
                            sclk_reg <= 1'b1;
                            rx_reg   <= {rx_reg[46:0], cipo};
                        end
                    end else begin
                        div_reg <= div_reg + DIV_W'(1);
                    end
                end
                S_PUBLISH: begin
                    gx_reg    <= rx_reg[47:32];
                    gy_reg    <= rx_reg[31:16];
                    gz_reg    <= rx_reg[15:0];
                    valid_reg <= 1'b1;
                    div_reg   <= '0;
                    state_reg <= S_GAP;
                end
                S_GAP: begin
                    if (div_reg == DIV_LAST) begin
                        div_reg <= '0;
                        if (!is_read_reg)
                            init_done_reg <= 1'b1;
                        state_reg <= S_WAIT_TICK;
                    end else begin
                        div_reg <= div_reg + DIV_W'(1);
                    end
                end
                default: state_reg <= S_INIT_START;
            endcase
        end
    end

    assign copi      = copi_reg;
    assign sclk      = sclk_reg;
    assign cs_n      = cs_n_reg;
    assign gx        = gx_reg;
    assign gy        = gy_reg;
    assign gz        = gz_reg;
    assign valid     = valid_reg;
    assign init_done = init_done_reg;
    assign overrun   = overrun_reg;
endmodule
